// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: FSM state encodings and default operand width
package serial_subtractor_pkg;
   localparam int DEF_WIDTH = 8;
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: request/result bundle between a requester and the serial subtractor
interface serial_subtractor_if
   import serial_subtractor_pkg::*;
#(parameter int WIDTH = DEF_WIDTH);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             ovf;
   modport master(output start, a, b, bin, input busy, done, diff, bout, ovf);
   modport slave(input start, a, b, bin, output busy, done, diff, bout, ovf);
endinterface

// File: rtl/serial_subtractor_fs_cell.sv
// fs_cell: combinational full-subtractor bit cell computing x - y - z
module fs_cell (
   input  logic x,
   input  logic y,
   input  logic z,
   output logic d,
   output logic b
);
   assign d = x ^ y ^ z;
   assign b = (~x & y) | (~x & z) | (y & z);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one fs_cell iterated over WIDTH clocks
module serial_subtractor
   import serial_subtractor_pkg::*;
#(parameter int WIDTH = DEF_WIDTH) (
   input logic              clock,
   input logic              reset,
   serial_subtractor_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, r_sh_q, r_sh_d, diff_q, diff_d;
   logic             brw_q, brw_d, bout_q, bout_d, ovf_q, ovf_d;
   logic             cell_d, cell_b;
   fs_cell u_cell (.x(a_sh_q[0]), .y(b_sh_q[0]), .z(brw_q), .d(cell_d), .b(cell_b));
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      r_sh_d  = r_sh_q;
      brw_d   = brw_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
      ovf_d   = ovf_q;
      if (state_q == SHIFT) begin
         r_sh_d = {cell_d, r_sh_q[WIDTH-1:1]};
         brw_d  = cell_b;
         a_sh_d = a_sh_q >> 1;
         b_sh_d = b_sh_q >> 1;
         cnt_d  = cnt_q + 1'b1;
         // brw_q still holds the borrow into the MSB on the final bit
         if (cnt_q == LAST) begin
            state_d = DONE;
            diff_d  = r_sh_d;
            bout_d  = cell_b;
            ovf_d   = brw_q ^ cell_b;
         end
      end else if (bus.start) begin
         state_d = SHIFT;
         a_sh_d  = bus.a;
         b_sh_d  = bus.b;
         brw_d   = bus.bin;
         cnt_d   = '0;
      end else begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         r_sh_q  <= '0;
         brw_q   <= 1'b0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         r_sh_q  <= r_sh_d;
         brw_q   <= brw_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         ovf_q   <= ovf_d;
      end
   end
   assign bus.busy = (state_q == SHIFT);
   assign bus.done = (state_q == DONE);
   assign bus.diff = diff_q;
   assign bus.bout = bout_q;
   assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized checks of serial_subtractor (WIDTH 8 and 5) against an arithmetic model
module tb_serial_subtractor;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   errors = 0;
   int   checks = 0;
   logic fx, fy, fz, fd, fb;
   serial_subtractor_if #(.WIDTH(8)) i8 ();
   serial_subtractor_if #(.WIDTH(5)) i5 ();
   serial_subtractor #(.WIDTH(8)) d8 (.clock(clock), .reset(reset), .bus(i8));
   serial_subtractor #(.WIDTH(5)) d5 (.clock(clock), .reset(reset), .bus(i5));
   fs_cell u_fs (.x(fx), .y(fy), .z(fz), .d(fd), .b(fb));
   always #5 clock = ~clock;
   function automatic void ref_sub(input int w, input int a, input int b, input int bi,
                                   output int d, output int bo, output int ov);
      int r, sa, sb, sr;
      r  = a - b - bi;
      sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
      sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
      sr = sa - sb - bi;
      d  = r & ((1 << w) - 1);
      bo = (r < 0) ? 1 : 0;
      ov = (sr < -(1 << (w - 1)) || sr > (1 << (w - 1)) - 1) ? 1 : 0;
   endfunction
   task automatic op8(input int a, input int b, input int bi,
                      output int d, output int bo, output int ov, output int lat, output int bc);
      @(negedge clock);
      i8.start = 1'b1; i8.a = 8'(a); i8.b = 8'(b); i8.bin = 1'(bi);
      @(negedge clock);
      i8.start = 1'b0; i8.a = 8'($urandom); i8.b = 8'($urandom); i8.bin = 1'($urandom);
      lat = -1;
      bc = 0;
      for (int c = 1; c <= 40 && lat < 0; c++) begin
         bc += int'(i8.busy);
         @(negedge clock);
         if (i8.done) lat = c;
      end
      d = int'(i8.diff); bo = int'(i8.bout); ov = int'(i8.ovf);
   endtask
   task automatic op5(input int a, input int b, input int bi,
                      output int d, output int bo, output int ov, output int lat, output int bc);
      @(negedge clock);
      i5.start = 1'b1; i5.a = 5'(a); i5.b = 5'(b); i5.bin = 1'(bi);
      @(negedge clock);
      i5.start = 1'b0; i5.a = 5'($urandom); i5.b = 5'($urandom); i5.bin = 1'($urandom);
      lat = -1;
      bc = 0;
      for (int c = 1; c <= 40 && lat < 0; c++) begin
         bc += int'(i5.busy);
         @(negedge clock);
         if (i5.done) lat = c;
      end
      d = int'(i5.diff); bo = int'(i5.bout); ov = int'(i5.ovf);
   endtask
   task automatic test_reset();
      i8.start = 1'b0; i8.a = '0; i8.b = '0; i8.bin = 1'b0;
      i5.start = 1'b0; i5.a = '0; i5.b = '0; i5.bin = 1'b0;
      repeat (3) @(negedge clock);
      checks++;
      if ({i8.busy, i8.done, i8.diff, i8.bout, i8.ovf} !== 12'h000) begin
         errors++;
         $display("FAIL reset8 got busy=%b done=%b diff=%h bout=%b ovf=%b want all 0",
                  i8.busy, i8.done, i8.diff, i8.bout, i8.ovf);
      end
      checks++;
      if ({i5.busy, i5.done, i5.diff, i5.bout, i5.ovf} !== 9'h000) begin
         errors++;
         $display("FAIL reset5 got busy=%b done=%b diff=%h bout=%b ovf=%b want all 0",
                  i5.busy, i5.done, i5.diff, i5.bout, i5.ovf);
      end
      reset = 1'b0;
      @(negedge clock);
      checks++;
      if ({i8.busy, i8.done} !== 2'b00) begin
         errors++;
         $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", i8.busy, i8.done);
      end
   endtask
   task automatic test_fs_cell();
      int x, y, z;
      for (int i = 0; i < 8; i++) begin
         x = (i >> 2) & 1; y = (i >> 1) & 1; z = i & 1;
         fx = 1'(x); fy = 1'(y); fz = 1'(z);
         #1;
         checks++;
         if (fd !== 1'((x + y + z) & 1) || fb !== ((x - y - z) < 0)) begin
            errors++;
            $display("FAIL fs_cell xyz=%0d%0d%0d got D=%b B=%b want D=%0d B=%0d",
                     x, y, z, fd, fb, (x + y + z) & 1, (x - y - z) < 0);
         end
      end
   endtask
   task automatic test_basic();
      int d, bo, ov, lat, bc;
      op8(8'h05, 8'h03, 0, d, bo, ov, lat, bc);
      checks++;
      if (d !== 8'h02 || bo !== 0 || ov !== 0 || lat !== 8) begin
         errors++;
         $display("FAIL basic_05_03 got diff=%h bout=%0d ovf=%0d lat=%0d want 02 0 0 8", d, bo, ov, lat);
      end
      @(negedge clock);
      checks++;
      if (i8.done !== 1'b0) begin
         errors++;
         $display("FAIL done_width got done=%b one cycle later want 0", i8.done);
      end
      op8(8'h03, 8'h05, 0, d, bo, ov, lat, bc);
      checks++;
      if (d !== 8'hFE || bo !== 1 || ov !== 0) begin
         errors++;
         $display("FAIL basic_03_05 got diff=%h bout=%0d ovf=%0d want fe 1 0", d, bo, ov);
      end
   endtask
   task automatic test_boundary();
      int d, bo, ov, lat, bc;
      op8(8'h80, 8'h01, 0, d, bo, ov, lat, bc);
      checks++;
      if (d !== 8'h7F || bo !== 0 || ov !== 1) begin
         errors++;
         $display("FAIL bound_80_01 got diff=%h bout=%0d ovf=%0d want 7f 0 1", d, bo, ov);
      end
      op8(8'h00, 8'h00, 1, d, bo, ov, lat, bc);
      checks++;
      if (d !== 8'hFF || bo !== 1 || ov !== 0) begin
         errors++;
         $display("FAIL bound_00_00_bin got diff=%h bout=%0d ovf=%0d want ff 1 0", d, bo, ov);
      end
   endtask
   task automatic test_start_ignored();
      int nd, tc, d;
      @(negedge clock);
      i8.start = 1'b1; i8.a = 8'h37; i8.b = 8'h12; i8.bin = 1'b0;
      @(negedge clock);
      nd = 0; tc = -1; d = -1;
      for (int c = 1; c <= 20; c++) begin
         i8.start = (c == 3 || c == 5);
         i8.a = 8'($urandom); i8.b = 8'($urandom); i8.bin = 1'($urandom);
         @(negedge clock);
         if (i8.done) begin
            nd++; tc = c; d = int'(i8.diff);
         end
      end
      i8.start = 1'b0;
      checks++;
      if (nd !== 1 || tc !== 8 || d !== 8'h25) begin
         errors++;
         $display("FAIL start_ignored got pulses=%0d at=%0d diff=%h want 1 8 25", nd, tc, d);
      end
   endtask
   task automatic test_back_to_back();
      int nd, t1, t2, d1, d2, o2;
      logic b8, b9;
      @(negedge clock);
      i8.start = 1'b1; i8.a = 8'hC3; i8.b = 8'h3C; i8.bin = 1'b1;
      @(negedge clock);
      nd = 0; t1 = -1; t2 = -1; d1 = -1; d2 = -1; o2 = -1; b8 = 1'bx; b9 = 1'bx;
      for (int c = 1; c <= 20; c++) begin
         i8.start = (c == 8 || c == 9);
         i8.a = (c >= 8) ? 8'h80 : 8'($urandom);
         i8.b = (c >= 8) ? 8'h01 : 8'($urandom);
         i8.bin = (c >= 8) ? 1'b0 : 1'($urandom);
         @(negedge clock);
         if (c == 8) b8 = i8.busy;
         if (c == 9) b9 = i8.busy;
         if (i8.done) begin
            nd++;
            if (nd == 1) begin t1 = c; d1 = int'(i8.diff); end
            else begin t2 = c; d2 = int'(i8.diff); o2 = int'(i8.ovf); end
         end
      end
      i8.start = 1'b0;
      checks++;
      if (nd !== 2 || t1 !== 8 || d1 !== 8'h86) begin
         errors++;
         $display("FAIL b2b_first got pulses=%0d at=%0d diff=%h want 2 8 86", nd, t1, d1);
      end
      checks++;
      if (t2 !== 17 || d2 !== 8'h7F || o2 !== 1) begin
         errors++;
         $display("FAIL b2b_second got at=%0d diff=%h ovf=%0d want 17 7f 1", t2, d2, o2);
      end
      checks++;
      if (b8 !== 1'b0 || b9 !== 1'b1) begin
         errors++;
         $display("FAIL b2b_no_idle got busy@8=%b busy@9=%b want 0 1", b8, b9);
      end
   endtask
   task automatic test_reset_abort();
      int nd, d, bo, ov, lat, bc;
      @(negedge clock);
      i8.start = 1'b1; i8.a = 8'h55; i8.b = 8'h22; i8.bin = 1'b0;
      @(negedge clock);
      i8.start = 1'b0;
      repeat (3) @(negedge clock);
      @(posedge clock);
      #1 reset = 1'b1;
      #1;
      checks++;
      if ({i8.busy, i8.done, i8.diff, i8.bout, i8.ovf} !== 12'h000) begin
         errors++;
         $display("FAIL abort_outputs got busy=%b done=%b diff=%h bout=%b ovf=%b want all 0",
                  i8.busy, i8.done, i8.diff, i8.bout, i8.ovf);
      end
      nd = 0;
      repeat (3) begin
         @(negedge clock);
         nd += int'(i8.done);
      end
      reset = 1'b0;
      repeat (12) begin
         @(negedge clock);
         nd += int'(i8.done);
      end
      checks++;
      if (nd !== 0) begin
         errors++;
         $display("FAIL abort_no_done got pulses=%0d want 0", nd);
      end
      op8(8'h10, 8'h01, 0, d, bo, ov, lat, bc);
      checks++;
      if (d !== 8'h0F || lat !== 8) begin
         errors++;
         $display("FAIL abort_restart got diff=%h lat=%0d want 0f 8", d, lat);
      end
   endtask
   task automatic test_random();
      int a, b, bi, d, bo, ov, lat, bc, ed, ebo, eov;
      for (int i = 0; i < 1000; i++) begin
         a = int'($urandom_range(0, 255)); b = int'($urandom_range(0, 255)); bi = int'($urandom_range(0, 1));
         op8(a, b, bi, d, bo, ov, lat, bc);
         ref_sub(8, a, b, bi, ed, ebo, eov);
         checks++;
         if (d !== ed || bo !== ebo || ov !== eov || lat !== 8 || bc !== 8) begin
            errors++;
            $display("FAIL rand8 %h-%h-%0d got diff=%h bout=%0d ovf=%0d lat=%0d busy=%0d want %h %0d %0d 8 8",
                     a, b, bi, d, bo, ov, lat, bc, ed, ebo, eov);
         end
      end
      for (int i = 0; i < 1000; i++) begin
         a = int'($urandom_range(0, 31)); b = int'($urandom_range(0, 31)); bi = int'($urandom_range(0, 1));
         op5(a, b, bi, d, bo, ov, lat, bc);
         ref_sub(5, a, b, bi, ed, ebo, eov);
         checks++;
         if (d !== ed || bo !== ebo || ov !== eov || lat !== 5 || bc !== 5) begin
            errors++;
            $display("FAIL rand5 %h-%h-%0d got diff=%h bout=%0d ovf=%0d lat=%0d busy=%0d want %h %0d %0d 5 5",
                     a, b, bi, d, bo, ov, lat, bc, ed, ebo, eov);
         end
      end
   endtask
   initial begin
      test_reset();
      test_fs_cell();
      test_basic();
      test_boundary();
      test_start_ignored();
      test_back_to_back();
      test_reset_abort();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
